// File: rtl/bcd2bin_if.sv
// Handshake bundle between the BCD entry logic and the packed-BCD to
// binary converter. The entry side is the master: it drives the
// request and the operand. The converter is the slave: it returns the
// status and the result.
interface bcd2bin_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Each clock shifts the {bcd, bin} working register right by one bit.
// Then every BCD digit that reads 8 or more is reduced by 3. After
// BIN_W shifts, the bin field holds the binary value of the operand.
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN. When it is defined,
// err flags an operand that contains a digit above 9.
module bcd2bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic      clk,
    input  logic      rst_n,
    bcd2bin_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int REG_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  iter_cnt;
    logic [REG_W-1:0]  work_reg;
    logic [REG_W-1:0]  work_nxt;
    logic [BIN_W-1:0]  bin_q;
    logic              accept;
    logic              last_iter;

    // State register; an asynchronous reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; start is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                bus.busy = 1'b1;
                if (iter_cnt == LAST_ITER) begin
                    last_iter = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // One reverse double-dabble step: shift right, then correct digits >= 8
    always_comb begin
        work_nxt = work_reg >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_nxt[BIN_W+4*d +: 4] >= 4'd8) begin
                work_nxt[BIN_W+4*d +: 4] = work_nxt[BIN_W+4*d +: 4] - 4'd3;
            end
        end
    end

    // Working register, iteration counter and the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg <= '0;
            iter_cnt <= '0;
            bin_q    <= '0;
        end else if (accept) begin
            work_reg <= {bus.bcd_in, {BIN_W{1'b0}}};
            iter_cnt <= '0;
        end else if (state == ST_CONV) begin
            work_reg <= work_nxt;
            iter_cnt <= iter_cnt + CNT_W'(1);
            if (last_iter) begin
                bin_q <= work_nxt[BIN_W-1:0];
            end
        end
    end

    assign bus.bin_out = bin_q;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q;
    logic digit_bad;

    // Flag any operand digit above 9 at the moment it is accepted
    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.bcd_in[4*d +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    // The error flag is held until the next accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= digit_bad;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
